if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_pc_reg.sv | 29 ++
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_stage_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding on the current PC
        S_HOLD  = 2'd1,   // instruction captured, waiting for ID to accept it
        S_DROP  = 2'd2    // redirect arrived mid-wait; discard the pending response
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Control-flow targets are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with load enable and synchronous reset.
module if_pc_reg
    import if_fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] next_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next-PC mux: take the new value only when loading.
    always_comb begin
        pc_d = pc_q;
        if (load_i) pc_d = next_pc_i;
    end

    // PC state, reset to the boot address.
    always_ff @(posedge clk_i) begin
        if (reset_i) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory handshake, stall buffering
// and squashing of responses made stale by a branch or jump.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_if,
    output logic [31:0] inst_if,
    output logic        if_valid,
    output logic        idflush
);

    fetch_state_e state_q, state_d;
    logic [31:0]  inst_buf_q, inst_buf_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         pc_load;
    logic [31:0]  pc_next;
    logic         redirect;
    logic [31:0]  target;

    // A redirect is only honoured when the hazard unit lets the PC move.
    assign redirect = (branch_taken | jump) & pc_write;
    assign target   = align_word(branch_taken ? branch_target : jump_target);
    assign pc_plus4 = pc + PC_STEP;

    // The fetch address is always the architectural PC; a stale request in
    // S_DROP keeps its old address until the memory answers.
    assign imem_addr = pc;
    assign idflush   = redirect & ~reset;

    if_pc_reg u_pc_reg (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (pc_load),
        .next_pc_i (pc_next),
        .pc_o      (pc)
    );

    // Next-state and output decode; reset forces every presented output low.
    always_comb begin
        state_d    = state_q;
        inst_buf_d = inst_buf_q;
        pend_tgt_d = pend_tgt_q;
        pc_load    = 1'b0;
        pc_next    = pc_plus4;
        imem_req   = 1'b0;
        inst_if    = INST_NOP;
        pc_if      = 32'h0;
        if_valid   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect) begin
                        pc_load = 1'b1;
                        pc_next = target;
                    end else if (pc_write) begin
                        inst_if  = imem_rdata;
                        pc_if    = pc_plus4;
                        if_valid = 1'b1;
                        pc_load  = 1'b1;
                    end else begin
                        inst_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    pend_tgt_d = target;
                    state_d    = S_DROP;
                end
            end
            S_HOLD: begin
                inst_if  = inst_buf_q;
                pc_if    = pc_plus4;
                if_valid = 1'b1;
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_next = target;
                    state_d = S_FETCH;
                end else if (pc_write) begin
                    pc_load = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                imem_req = 1'b1;
                if (redirect) pend_tgt_d = target;
                if (imem_ready) begin
                    pc_load = 1'b1;
                    pc_next = redirect ? target : pend_tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            imem_req = 1'b0;
            inst_if  = INST_NOP;
            pc_if    = 32'h0;
            if_valid = 1'b0;
        end
    end

    // Controller state, stall buffer and pending redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            inst_buf_q <= INST_NOP;
            pend_tgt_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            inst_buf_q <= inst_buf_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_if;
    logic [31:0] inst_if;
    logic        if_valid;
    logic        idflush;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc_if         (pc_if),
        .inst_if       (inst_if),
        .if_valid      (if_valid),
        .idflush       (idflush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        imem_rdata    = 32'h0;
        imem_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One zero-wait fetch at the expected address, consumed by ID.
    task automatic fetch_ok(input string tag, input logic [31:0] addr, input logic [31:0] word);
        pc_write   = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = word;
        #1;
        chk({tag, "_addr"},  imem_addr, addr);
        chk({tag, "_inst"},  inst_if,   word);
        chk({tag, "_pcif"},  pc_if,     addr + 32'd4);
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset with hostile inputs: everything forced low, no flush.
        branch_taken = 1'b1;
        imem_ready   = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        tick();
        tick();
        #1;
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_flush", {31'h0, idflush},  32'h0);
        chk("rst_inst",  inst_if, 32'h0);
        chk("rst_pcif",  pc_if,   32'h0);

        // Zero-wait streaming: addresses 0,4,8,12.
        do_reset();
        fetch_ok("zw0", 32'h0, 32'h1000_0000);
        fetch_ok("zw1", 32'h4, 32'h1000_0004);
        fetch_ok("zw2", 32'h8, 32'h1000_0008);
        fetch_ok("zw3", 32'hC, 32'h1000_000C);

        // Two wait states at address 8.
        do_reset();
        fetch_ok("ws0", 32'h0, 32'h2000_0000);
        fetch_ok("ws1", 32'h4, 32'h2000_0004);
        for (int i = 0; i < 2; i++) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hBAD0_BAD0;
            #1;
            chk("ws_wait_valid", {31'h0, if_valid}, 32'h0);
            chk("ws_wait_inst",  inst_if, 32'h0);
            chk("ws_wait_addr",  imem_addr, 32'h8);
            chk("ws_wait_req",   {31'h0, imem_req}, 32'h1);
            tick();
        end
        fetch_ok("ws2", 32'h8, 32'h2000_0008);
        imem_ready = 1'b0;
        #1;
        chk("ws_next_addr", imem_addr, 32'hC);

        // Stall: response at 4 while pc_write=0, then held three cycles.
        do_reset();
        fetch_ok("st0", 32'h0, 32'h3000_0000);
        pc_write   = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h3000_0004;
        #1;
        chk("st_cap_valid", {31'h0, if_valid}, 32'h0);
        chk("st_cap_req",   {31'h0, imem_req}, 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            pc_write   = (i == 2);
            imem_rdata = 32'hFFFF_0000 + i;
            #1;
            chk("st_hold_inst",  inst_if, 32'h3000_0004);
            chk("st_hold_pcif",  pc_if,   32'h8);
            chk("st_hold_valid", {31'h0, if_valid}, 32'h1);
            chk("st_hold_req",   {31'h0, imem_req}, 32'h0);
            tick();
        end
        imem_ready = 1'b0;
        #1;
        chk("st_rel_req",  {31'h0, imem_req}, 32'h1);
        chk("st_rel_addr", imem_addr, 32'h8);

        // Redirect while waiting on 0x10: response discarded, fetch 0x40.
        do_reset();
        fetch_ok("rd0", 32'h0, 32'h4000_0000);
        fetch_ok("rd1", 32'h4, 32'h4000_0004);
        fetch_ok("rd2", 32'h8, 32'h4000_0008);
        fetch_ok("rd3", 32'hC, 32'h4000_000C);
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        #1;
        chk("rd_flush",     {31'h0, idflush},  32'h1);
        chk("rd_flush_vld", {31'h0, if_valid}, 32'h0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("rd_drop_flush", {31'h0, idflush},  32'h0);
        chk("rd_drop_addr",  imem_addr, 32'h10);
        chk("rd_drop_req",   {31'h0, imem_req}, 32'h1);
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_0010;
        #1;
        chk("rd_disc_valid", {31'h0, if_valid}, 32'h0);
        chk("rd_disc_inst",  inst_if, 32'h0);
        tick();
        fetch_ok("rd_tgt", 32'h40, 32'h4000_0040);

        // Wrap at the top of memory, then branch beats jump.
        do_reset();
        imem_ready  = 1'b1;
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        #1;
        chk("wr_jflush", {31'h0, idflush},  32'h1);
        chk("wr_jvalid", {31'h0, if_valid}, 32'h0);
        tick();
        jump = 1'b0;
        fetch_ok("wr_top", 32'hFFFF_FFFC, 32'h5000_FFFC);
        imem_ready    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h81;
        jump          = 1'b1;
        jump_target   = 32'h100;
        #1;
        chk("wr_wrap_addr", imem_addr, 32'h0);
        chk("wr_pri_flush", {31'h0, idflush}, 32'h1);
        tick();
        idle_inputs();
        #1;
        chk("wr_pri_addr", imem_addr, 32'h80);

        // Reset in the middle of S_DROP; later ready is a normal fetch of 0.
        do_reset();
        jump        = 1'b1;
        jump_target = 32'h200;
        #1;
        chk("rs_flush", {31'h0, idflush}, 32'h1);
        tick();
        jump  = 1'b0;
        reset = 1'b1;
        #1;
        chk("rs_req",   {31'h0, imem_req}, 32'h0);
        chk("rs_valid", {31'h0, if_valid}, 32'h0);
        chk("rs_inst",  inst_if, 32'h0);
        tick();
        reset = 1'b0;
        fetch_ok("rs_late", 32'h0, 32'h6000_005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
